fetch_prefetch_unit: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF_ID pipeline register.
- Owns the fetch PC and issues one-outstanding read requests to a variable-latency instruction memory using a req/ack + rvalid handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with valid/ready, so a decode stall does not stall memory.
- A redirect from the branch resolution logic (taken BranchEq/BranchGt in EX_MEM) flushes the buffer and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_prefetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_prefetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

  localparam int INST_W   = 32;
  localparam int PC_INC   = 4;
  localparam int PC_W_MAX = 64;

  // PC is stored at the widest supported width; narrower XLEN zero-extends.
  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small power-of-two FIFO with flush priority over push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             hold, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO freezes everything, including a coincident pop.
  assign hold    = push && full;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush && !hold;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (reset) !(push && full && !flush))
    else $error("fetch_fifo: push while full");

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - fetch PC owner, one-outstanding memory requester and decode buffer
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready
);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CAW = CW + 1;

  fetch_state_t  state, state_next;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CAW-1:0] count_after;
  fetch_entry_t  wr_entry, rd_entry;

  assign push     = (state == WAIT) && mem_rvalid;
  assign pop      = !empty && inst_ready;
  assign wr_entry = '{pc: PC_W_MAX'(req_pc), inst: mem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
    end else if (state == REQ && mem_ack) begin
      fetch_pc <= fetch_pc + XLEN'(PC_INC);
      req_pc   <= fetch_pc;
    end
  end

  always_comb begin
    state_next  = state;
    count_after = {1'b0, count} + CAW'(push) - CAW'(pop);
    if (redirect_valid) begin
      // DROP only while a response is still owed; a response landing this cycle settles it.
      if ((state == REQ && mem_ack) || ((state == WAIT || state == DROP) && !mem_rvalid))
        state_next = DROP;
      else
        state_next = REQ;
    end else begin
      case (state)
        IDLE:    if (!full) state_next = REQ;
        REQ:     if (mem_ack) state_next = WAIT;
        WAIT:    if (mem_rvalid) state_next = (count_after < CAW'(DEPTH)) ? REQ : IDLE;
        DROP:    if (mem_rvalid) state_next = REQ;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req    = (state == REQ);
    mem_addr   = fetch_pc;
    inst_valid = !empty;
    inst       = '0;
    inst_pc    = '0;
    if (!empty) begin
      inst    = rd_entry.inst;
      inst_pc = rd_entry.pc[XLEN-1:0];
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready = 1'b1;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic        ack_en = 1'b1;
  logic        rv_en = 1'b1;
  logic        pend = 1'b0;
  logic [63:0] pend_addr = '0;
  logic [63:0] ack_addrs[$];
  int          ack_cycs[$];
  logic [63:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_cyc[$];

  fetch_prefetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] img(logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: acks every request when enabled, answers one cycle later when enabled.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (!reset) begin
        if (pend && rv_en) begin
          mem_rvalid = 1'b1;
          mem_rdata  = img(pend_addr);
          pend       = 1'b0;
        end
        if (mem_req && ack_en) begin
          mem_ack   = 1'b1;
          pend      = 1'b1;
          pend_addr = mem_addr;
          ack_addrs.push_back(mem_addr);
          ack_cycs.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
      got_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_redirect(logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_got(string tag, int n);
    for (int i = 0; i < 80; i++) begin
      if (got_pc.size() >= n) break;
      step();
    end
    check(tag, 64'(got_pc.size() >= n), 64'd1);
  endtask

  task automatic wait_pend(string tag, logic [63:0] addr, logic any_addr, logic need_valid);
    for (int i = 0; i < 80; i++) begin
      if (pend && (any_addr || pend_addr == addr) && (!need_valid || inst_valid)) break;
      step();
    end
    check(tag, 64'(pend), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ab, gb;
    step();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'h0);
    check("rst_inst_pc", inst_pc, 64'h0);
    step();
    reset = 1'b0;

    // Streaming fetch with ready held high
    wait_got("t1_wait", 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_ack_addr%0d", i), ack_addrs[i], 64'(4 * i));
      check($sformatf("t1_inst_pc%0d", i), got_pc[i], 64'(4 * i));
      check($sformatf("t1_inst%0d", i), 64'(got_inst[i]), 64'(img(64'(4 * i))));
    end
    check("t1_latency", 64'(got_cyc[0] - ack_cycs[0]), 64'd2);

    // Decode stall fills the FIFO, then drains in order
    inst_ready = 1'b0;
    do_reset();
    ab = ack_addrs.size();
    gb = got_pc.size();
    repeat (20) step();
    check("t2_ack_count", 64'(ack_addrs.size() - ab), 64'd4);
    check("t2_ack_last", ack_addrs[ab + 3], 64'hC);
    check("t2_mem_req", 64'(mem_req), 64'd0);
    check("t2_head_valid", 64'(inst_valid), 64'd1);
    check("t2_head_pc", inst_pc, 64'h0);
    inst_ready = 1'b1;
    wait_got("t2_wait", gb + 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_drain_pc%0d", i), got_pc[gb + i], 64'(4 * i));
    check("t2_drain_back2back", 64'(got_cyc[gb + 3] - got_cyc[gb]), 64'd3);

    // Redirect while WAIT for 0x8
    do_reset();
    wait_pend("t3_wait_8", 64'h8, 1'b0, 1'b0);
    rv_en = 1'b0;
    do_redirect(64'h100);
    check("t3_flushed", 64'(inst_valid), 64'd0);
    check("t3_drop_no_req", 64'(mem_req), 64'd0);
    ab = ack_addrs.size();
    gb = got_pc.size();
    rv_en = 1'b1;
    wait_got("t3_wait", gb + 1);
    check("t3_next_addr", ack_addrs[ab], 64'h100);
    check("t3_next_pc", got_pc[gb], 64'h100);
    check("t3_next_inst", 64'(got_inst[gb]), 64'hC0DE0100);

    // Redirect coincident with mem_ack
    for (int i = 0; i < 40; i++) begin
      if (mem_req) break;
      step();
    end
    check("t4_in_req", 64'(mem_req), 64'd1);
    ab = ack_addrs.size();
    do_redirect(64'h203);
    check("t4_drop_no_req", 64'(mem_req), 64'd0);
    gb = got_pc.size();
    wait_got("t4_wait", gb + 1);
    check("t4_restart_addr", ack_addrs[ab + 1], 64'h200);
    check("t4_restart_pc", got_pc[gb], 64'h200);
    check("t4_restart_inst", 64'(got_inst[gb]), 64'hC0DE0200);

    // Redirect with simultaneous pop and rvalid
    inst_ready = 1'b0;
    wait_pend("t5_setup", 64'h0, 1'b1, 1'b1);
    inst_ready = 1'b1;
    do_redirect(64'h300);
    check("t5_inst_valid", 64'(inst_valid), 64'd0);
    check("t5_inst_zero", 64'(inst), 64'h0);
    check("t5_mem_req", 64'(mem_req), 64'd1);
    check("t5_mem_addr", mem_addr, 64'h300);
    gb = got_pc.size();
    wait_got("t5_wait", gb + 1);
    check("t5_first_pc", got_pc[gb], 64'h300);

    // Reset mid-WAIT, stale rvalid afterward
    wait_pend("t6_setup", 64'h0, 1'b1, 1'b0);
    rv_en = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_req", 64'(mem_req), 64'd0);
    check("t6_rst_addr", mem_addr, 64'h0);
    check("t6_rst_valid", 64'(inst_valid), 64'd0);
    step();
    step();
    reset = 1'b0;
    rv_en = 1'b1;
    ab = ack_addrs.size();
    gb = got_pc.size();
    wait_got("t6_wait", gb + 1);
    check("t6_first_addr", ack_addrs[ab], 64'h0);
    check("t6_first_pc", got_pc[gb], 64'h0);
    check("t6_first_inst", 64'(got_inst[gb]), 64'hC0DE0000);

    // PC wrap at the top of the address space
    ack_en = 1'b0;
    repeat (4) step();
    ab = ack_addrs.size();
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_mem_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    gb = got_pc.size();
    ack_en = 1'b1;
    wait_got("t7_wait", gb + 2);
    check("t7_ack_top", ack_addrs[ab], 64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_ack_wrap", ack_addrs[ab + 1], 64'h0);
    check("t7_pc_top", got_pc[gb], 64'hFFFF_FFFF_FFFF_FFFC);
    check("t7_pc_wrap", got_pc[gb + 1], 64'h0);
    check("t7_inst_top", 64'(got_inst[gb]), 64'hC0DEFFFC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
